// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, index and counter widths.
package dmem_pkg;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int unsigned DEPTH_WORDS_DEF = 256;
  localparam int unsigned IDX_W           = $clog2(DEPTH_WORDS_DEF);
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response valid-ready channels of the data-memory port.
interface dmem_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_word_array.sv
// Word storage with one synchronous write port and one synchronous read port.
module dmem_word_array #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request in flight, fixed-latency response, storage cleared after reset.
// Build option: define DMEM_RANGE_CHECK_EN to flag out-of-range addresses instead of aliasing.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned LATENCY     = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned ARR_IDX_W = $clog2(DEPTH_WORDS);

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [ARR_IDX_W-1:0] clr_idx;
  logic                 rsp_load;
  logic                 rsp_err_q;

  logic                 accept;
  logic                 addr_err;
  logic [ARR_IDX_W-1:0] idx;
  logic                 arr_we;
  logic                 arr_re;
  logic [ARR_IDX_W-1:0] arr_waddr;
  logic [DATA_W-1:0]    arr_wdata;
  logic [DATA_W-1:0]    arr_rdata;

  assign accept = (state == ST_IDLE) && bus.req_valid;
  assign idx    = bus.req_addr[ARR_IDX_W+1:2];

`ifdef DMEM_RANGE_CHECK_EN
  assign addr_err = |bus.req_addr[ADDR_W-1:ARR_IDX_W+2];
`else
  assign addr_err = 1'b0;
`endif

  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = idx;
    arr_wdata = bus.req_wdata;
    arr_re    = accept && !bus.req_we;
    if (state == ST_CLEAR) begin
      arr_we    = 1'b1;
      arr_waddr = clr_idx;
      arr_wdata = '0;
    end else if (accept && bus.req_we && !addr_err) begin
      arr_we = 1'b1;
    end
  end

  dmem_word_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (ARR_IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (idx),
    .rdata (arr_rdata)
  );

  // Every accept passes through WAIT (counter preloaded with LATENCY-1) so that
  // rsp_valid first rises after edge accept+LATENCY, LATENCY==1 included.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_CLEAR;
      cnt       <= '0;
      clr_idx   <= '0;
      rsp_load  <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == ARR_IDX_W'(DEPTH_WORDS - 1)) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_WAIT;
            cnt       <= CNT_W'(LATENCY - 1);
            rsp_load  <= !bus.req_we && !addr_err;
            rsp_err_q <= addr_err;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state     <= ST_IDLE;
            rsp_load  <= 1'b0;
            rsp_err_q <= 1'b0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // The array read register doubles as the response data register.
  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_rdata = rsp_load ? arr_rdata : '0;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a timestamp-based memory model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  logic clk;
  logic reset;

  dmem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_responder #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned  cyc = 0;
  logic         begun = 1'b0;
  logic         m_pend = 1'b0;
  int unsigned  m_acc = 0;
  int unsigned  m_ready_from = 32'hFFFF_FFFF;
  logic [31:0]  m_rdata = '0;
  logic         m_err = 1'b0;
  logic [31:0]  m_mem [DEPTH];

  function automatic logic addr_bad(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return a >= 32'(DEPTH * 4);
`else
    return (a != a);
`endif
  endfunction

  always @(posedge clk) begin : model
    logic vb, rb, bad;
    int unsigned i;
    vb = m_pend && (cyc >= m_acc + LAT);
    rb = begun && !m_pend && (cyc >= m_ready_from);
    cyc++;
    if (!reset) begin
      begun = 1'b1;
      m_pend = 1'b0;
      m_ready_from = cyc + DEPTH;
      foreach (m_mem[k]) m_mem[k] = '0;
    end else if (vb && bus.rsp_ready) begin
      m_pend = 1'b0;
      m_ready_from = cyc;
    end else if (rb && bus.req_valid) begin
      i = (bus.req_addr >> 2) % DEPTH;
      bad = addr_bad(bus.req_addr);
      m_pend = 1'b1;
      m_acc = cyc;
      m_err = bad;
      if (bus.req_we) begin
        if (!bad) m_mem[i] = bus.req_wdata;
        m_rdata = '0;
      end else begin
        m_rdata = bad ? 32'h0 : m_mem[i];
      end
    end
  end

  always @(negedge clk) begin : compare
    logic v, r;
    if (begun) begin
      v = m_pend && (cyc >= m_acc + LAT);
      r = !m_pend && (cyc >= m_ready_from);
      chk("req_ready", {31'b0, bus.req_ready}, {31'b0, r});
      chk("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, v});
      if (v) begin
        chk("rsp_rdata", bus.rsp_rdata, m_rdata);
        chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, m_err});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic accept_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    logic hs;
    int n;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    n = 0;
    hs = 1'b0;
    while (!hs && n < 1000) begin
      @(negedge clk);
      hs = (bus.req_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    bus.req_valid = 1'b0;
    if (!hs) chk("req_handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input int bp, output logic [31:0] rd, output logic er, output int lat);
    accept_req(we, addr, wdata);
    lat = 0;
    rd  = 'x;
    er  = 1'bx;
    while (lat < 64) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) break;
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 64) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    repeat (bp) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h10;
      bus.req_wdata = $urandom;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) break;
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] rd;
    logic        er;
    int          lat, n;

    reset = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset then clear window
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    wait_ready(n);
    chk("clear_cycles", n, 32'd256);

    // Store then load, latency and data
    txn(1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
    chk("store_rdata", rd, 32'h0);
    chk("store_latency", lat, LAT);
    txn(1'b0, 32'h10, 32'h0, 0, rd, er, lat);
    chk("load_rdata", rd, 32'hDEADBEEF);
    chk("load_latency", lat, LAT);

    // Low address bits ignored
    txn(1'b1, 32'h10, 32'h12345678, 0, rd, er, lat);
    txn(1'b0, 32'h13, 32'h0, 0, rd, er, lat);
    chk("load_lowbits", rd, 32'h12345678);

    // Back-pressure with concurrent junk request
    txn(1'b0, 32'h10, 32'h0, 5, rd, er, lat);
    chk("bp_rdata", rd, 32'h12345678);
    txn(1'b0, 32'h10, 32'h0, 0, rd, er, lat);
    chk("bp_junk_ignored", rd, 32'h12345678);

    // Aliasing / range check
    txn(1'b1, 32'h400, 32'hA5A5A5A5, 0, rd, er, lat);
`ifdef DMEM_RANGE_CHECK_EN
    chk("oor_store_err", {31'b0, er}, 32'd1);
    txn(1'b0, 32'h0, 32'h0, 0, rd, er, lat);
    chk("alias_load", rd, 32'h0);
`else
    chk("alias_store_err", {31'b0, er}, 32'd0);
    txn(1'b0, 32'h0, 32'h0, 0, rd, er, lat);
    chk("alias_load", rd, 32'hA5A5A5A5);
`endif

    // Reset while waiting on a load
    txn(1'b1, 32'h20, 32'h00000077, 0, rd, er, lat);
    accept_req(1'b0, 32'h20, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    wait_ready(n);
    chk("reset_clear_cycles", n, 32'd256);
    txn(1'b0, 32'h20, 32'h0, 0, rd, er, lat);
    chk("post_reset_load", rd, 32'h0);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      a = {26'(0), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FC00);
      txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), rd, er, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
